display_format: RTL

DISPLAY_FORMAT -- requirements
Module: display_format

---
 rtl/display_format_if.sv | 33 +++
 rtl/display_format.sv | 135 +++++++++++++
 2 files changed

// File: rtl/display_format_if.sv
// Request/result bundle between a binary value source and display_format.
// The master drives requests; the slave (display_format) returns the digit codes.
interface display_format_if #(
    parameter int unsigned IN_W = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_value;
    logic            in_hex;
    logic [31:0]     data;
    logic            done;
    logic            ovf;

    modport master (
        output in_valid,
        output in_value,
        output in_hex,
        input  in_ready,
        input  data,
        input  done,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  in_value,
        input  in_hex,
        output in_ready,
        output data,
        output done,
        output ovf
    );
endinterface

// File: rtl/display_format.sv
// Formats a binary value as eight hex or BCD digit codes for a seven-segment scanner.
// Define DISPLAY_FORMAT_OVF_EN to flag decimal results above 99_999_999 and show "EEEEEEEE".
module display_format #(
    parameter int unsigned IN_W = 32
) (
    input logic             clk,
    input logic             rst,
    display_format_if.slave bus
);

    localparam int unsigned CntW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(IN_W - 1);

    typedef enum logic {StIdle, StConv} state_e;

    state_e          state_q, state_d;
    logic [IN_W-1:0] shreg_q, shreg_d;
    logic [39:0]     bcd_q, bcd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     data_q, data_d;
    logic            done_q, done_d;
`ifdef DISPLAY_FORMAT_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [39:0] bcd_adj;
    logic [39:0] bcd_shift;
    logic        unused_bcd_top;

    // Add-3 correction on every digit that would exceed 9 after doubling.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    assign bcd_shift      = {bcd_adj[38:0], shreg_q[IN_W-1]};
    assign unused_bcd_top = bcd_adj[39];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
`ifdef DISPLAY_FORMAT_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_hex) begin
                        data_d = 32'(bus.in_value);
                        // Back-to-back hex updates still yield isolated done pulses.
                        done_d = ~done_q;
`ifdef DISPLAY_FORMAT_OVF_EN
                        ovf_d  = 1'b0;
`endif
                    end else begin
                        shreg_d = bus.in_value;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        state_d = StConv;
                    end
                end
            end
            StConv: begin
                bcd_d   = bcd_shift;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
`ifdef DISPLAY_FORMAT_OVF_EN
                    if (bcd_shift[39:32] != 8'h00) begin
                        data_d = 32'hEEEE_EEEE;
                        ovf_d  = 1'b1;
                    end else begin
                        data_d = bcd_shift[31:0];
                        ovf_d  = 1'b0;
                    end
`else
                    data_d = bcd_shift[31:0];
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

`ifdef DISPLAY_FORMAT_OVF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready = (state_q == StIdle);
    assign bus.data     = data_q;
    assign bus.done     = done_q;

endmodule
